slice_double_buffer: RTL and testbench

- Ping-pong slice memory directly upstream of the framebuffer; it takes the place of the RAM emulator in the display pipeline.
- A producer (pattern generator or RGB capture) fills the back bank. The framebuffer reads the front bank through its ram_addr/ram_data port.
- Banks swap only on a framebuffer-side swap request, and only after the producer has completed a full slice. This prevents tearing mid-column.

---
 rtl/slice_double_buffer.sv | 112 +++++++++++
 tb/tb_slice_double_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/slice_double_buffer.sv
// Ping-pong slice memory feeding the framebuffer: a producer fills the back bank
// while the framebuffer reads the front bank, and banks swap only on a complete slice.
module slice_double_buffer #(
  parameter int SLICE_WORDS = 1920,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              w_enable,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_last,
  output logic              w_ready,
  input  logic              swap_req,
  output logic              swapped,
  output logic              front_valid,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic [7:0]        underrun_cnt
);

  // state      | meaning
  // ST_FILLING | back bank accepts producer writes
  // ST_FULL    | back bank holds a complete slice, waiting for swap_req
  localparam logic [0:0] ST_FILLING = 1'b0;
  localparam logic [0:0] ST_FULL    = 1'b1;
  localparam int         IDX_W      = $clog2(SLICE_WORDS);

  logic [0:0]        state_q, state_d;
  logic              front_q, front_d;
  logic              swapped_q, swapped_d;
  logic              front_valid_q, front_valid_d;
  logic [7:0]        underrun_q, underrun_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_sel_q, rd_sel_d;
  logic [DATA_W-1:0] rd0_q, rd1_q;

  logic [DATA_W-1:0] mem0 [SLICE_WORDS];
  logic [DATA_W-1:0] mem1 [SLICE_WORDS];

  logic              w_in_range, r_in_range;
  logic [IDX_W-1:0]  w_idx, r_idx;
  logic              write_ok, complete, mem_we, do_swap;

  assign w_in_range = (w_addr < ADDR_W'(SLICE_WORDS));
  assign r_in_range = (r_addr < ADDR_W'(SLICE_WORDS));
  assign w_idx      = w_addr[IDX_W-1:0];
  assign r_idx      = r_addr[IDX_W-1:0];
  assign write_ok   = (state_q == ST_FILLING) && w_enable;
  assign complete   = write_ok && w_last;
  assign mem_we     = write_ok && w_in_range;

  // Back bank is always the one not in front; the write in a swap cycle lands in the old back.
  always_ff @(posedge clk) begin
    if (mem_we && front_q)  mem0[w_idx] <= w_data;
    if (mem_we && !front_q) mem1[w_idx] <= w_data;
    rd0_q <= mem0[r_idx];
    rd1_q <= mem1[r_idx];
  end

  always_comb begin
    state_d       = state_q;
    front_d       = front_q;
    swapped_d     = 1'b0;
    front_valid_d = front_valid_q;
    underrun_d    = underrun_q;
    do_swap       = 1'b0;
    // A request right after a swap is refused so swapped never pulses back to back.
    if (swap_req && !swapped_q && ((state_q == ST_FULL) || complete)) begin
      do_swap = 1'b1;
    end
    if (do_swap) begin
      front_d       = ~front_q;
      swapped_d     = 1'b1;
      front_valid_d = 1'b1;
      state_d       = ST_FILLING;
    end else begin
      if (complete) state_d = ST_FULL;
      if (swap_req && (underrun_q != 8'hFF)) underrun_d = underrun_q + 8'd1;
    end
    rd_valid_d = front_valid_q && r_in_range;
    rd_sel_d   = front_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ST_FILLING;
      front_q       <= 1'b0;
      swapped_q     <= 1'b0;
      front_valid_q <= 1'b0;
      underrun_q    <= 8'd0;
      rd_valid_q    <= 1'b0;
      rd_sel_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      front_q       <= front_d;
      swapped_q     <= swapped_d;
      front_valid_q <= front_valid_d;
      underrun_q    <= underrun_d;
      rd_valid_q    <= rd_valid_d;
      rd_sel_q      <= rd_sel_d;
    end
  end

  assign w_ready      = (state_q == ST_FILLING);
  assign swapped      = swapped_q;
  assign front_valid  = front_valid_q;
  assign underrun_cnt = underrun_q;
  assign r_data       = rd_valid_q ? (rd_sel_q ? rd1_q : rd0_q) : '0;

endmodule

// File: tb/tb_slice_double_buffer.sv
// Directed bench for slice_double_buffer: fill, swap, underrun, simultaneous
// completion, write protection, aliasing and mid-fill asynchronous reset.
module tb_slice_double_buffer;

  logic        clk;
  logic        nrst;
  logic        w_enable;
  logic [31:0] w_addr;
  logic [15:0] w_data;
  logic        w_last;
  logic        w_ready;
  logic        swap_req;
  logic        swapped;
  logic        front_valid;
  logic [31:0] r_addr;
  logic [15:0] r_data;
  logic [7:0]  underrun_cnt;

  int n_checks = 0;
  int n_errors = 0;

  slice_double_buffer dut (
    .clk          (clk),
    .nrst         (nrst),
    .w_enable     (w_enable),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .w_last       (w_last),
    .w_ready      (w_ready),
    .swap_req     (swap_req),
    .swapped      (swapped),
    .front_valid  (front_valid),
    .r_addr       (r_addr),
    .r_data       (r_data),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rd(input int a, output logic [15:0] d);
    r_addr = 32'(a);
    tick();
    d = r_data;
  endtask

  task automatic fill(input int base, input int n, input bit last_at_end);
    for (int i = 0; i < n; i++) begin
      w_enable = 1'b1;
      w_addr   = 32'(i);
      w_data   = 16'(base + i);
      w_last   = last_at_end && (i == n - 1);
      tick();
    end
    w_enable = 1'b0;
    w_last   = 1'b0;
  endtask

  task automatic do_swap(input string tag);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk({tag, "_swapped"}, 32'(swapped), 32'd1);
    chk({tag, "_front_valid"}, 32'(front_valid), 32'd1);
    chk({tag, "_w_ready"}, 32'(w_ready), 32'd1);
    tick();
    chk({tag, "_swapped_drop"}, 32'(swapped), 32'd0);
  endtask

  initial begin
    logic [15:0] d;
    nrst = 1'b0; w_enable = 1'b0; w_addr = '0; w_data = '0; w_last = 1'b0;
    swap_req = 1'b0; r_addr = '0;

    // reset state
    repeat (3) tick();
    chk("rst_r_data", 32'(r_data), 32'd0);
    chk("rst_w_ready", 32'(w_ready), 32'd1);
    nrst = 1'b1;
    rd(0, d);    chk("rst_rd0", 32'(d), 32'd0);
    rd(1919, d); chk("rst_rd1919", 32'(d), 32'd0);
    chk("rst_front_valid", 32'(front_valid), 32'd0);
    chk("rst_underrun", 32'(underrun_cnt), 32'd0);
    chk("rst_swapped", 32'(swapped), 32'd0);

    // basic fill and swap
    fill(0, 1920, 1'b1);
    chk("fill_w_ready_low", 32'(w_ready), 32'd0);
    w_enable = 1'b1; w_addr = 32'd0; w_data = 16'hFFFF;
    tick();
    w_enable = 1'b0;
    chk("full_w_ready_low", 32'(w_ready), 32'd0);
    chk("full_no_swap", 32'(swapped), 32'd0);
    do_swap("swap1");
    rd(5, d);    chk("a_rd5", 32'(d), 32'h0005);
    rd(1919, d); chk("a_rd1919", 32'(d), 32'h077F);
    rd(0, d);    chk("a_rd0_protected", 32'(d), 32'h0000);
    rd(2000, d); chk("a_rd2000_oor", 32'(d), 32'h0000);

    // underrun
    for (int k = 0; k < 3; k++) begin
      swap_req = 1'b1;
      tick();
      chk("ur_no_swapped", 32'(swapped), 32'd0);
    end
    swap_req = 1'b0;
    tick();
    chk("ur_cnt3", 32'(underrun_cnt), 32'd3);
    rd(5, d); chk("ur_front_kept", 32'(d), 32'h0005);
    swap_req = 1'b1;
    repeat (251) tick();
    chk("ur_cnt254", 32'(underrun_cnt), 32'd254);
    tick();
    chk("ur_cnt255", 32'(underrun_cnt), 32'd255);
    repeat (48) tick();
    swap_req = 1'b0;
    tick();
    chk("ur_sat255", 32'(underrun_cnt), 32'd255);
    chk("ur_front_valid", 32'(front_valid), 32'd1);

    // simultaneous completion, out-of-range writes must not alias
    fill(16'h1000, 1919, 1'b0);
    w_enable = 1'b1; w_addr = 32'd2053; w_data = 16'hDEAD; tick();
    w_addr = 32'd2000; w_data = 16'hBEEF; tick();
    chk("oor_no_complete", 32'(w_ready), 32'd1);
    w_addr = 32'd1919; w_data = 16'hABCD; w_last = 1'b1; swap_req = 1'b1; r_addr = 32'd5;
    tick();
    w_enable = 1'b0; w_last = 1'b0; swap_req = 1'b0;
    chk("sim_swapped", 32'(swapped), 32'd1);
    chk("sim_w_ready", 32'(w_ready), 32'd1);
    chk("sim_old_front_read", 32'(r_data), 32'h0005);
    tick();
    chk("sim_swapped_drop", 32'(swapped), 32'd0);
    chk("sim_still_filling", 32'(w_ready), 32'd1);
    rd(1919, d); chk("sim_rd1919", 32'(d), 32'hABCD);
    rd(5, d);    chk("sim_rd5_no_alias", 32'(d), 32'h1005);
    rd(80, d);   chk("sim_rd80_no_alias", 32'(d), 32'h1050);
    rd(0, d);    chk("sim_rd0", 32'(d), 32'h1000);
    chk("sim_underrun_kept", 32'(underrun_cnt), 32'd255);

    // out-of-range write with w_last still completes the slice
    w_enable = 1'b1; w_addr = 32'd2000; w_data = 16'h5555; w_last = 1'b1;
    tick();
    w_enable = 1'b0; w_last = 1'b0;
    chk("oor_last_full", 32'(w_ready), 32'd0);
    do_swap("swap3");
    rd(0, d);    chk("b_rd0", 32'(d), 32'h0000);
    rd(1919, d); chk("b_rd1919", 32'(d), 32'h077F);

    // asynchronous reset in the middle of a fill
    fill(16'h2000, 1000, 1'b0);
    #2 nrst = 1'b0;
    #1;
    chk("mrst_front_valid", 32'(front_valid), 32'd0);
    chk("mrst_w_ready", 32'(w_ready), 32'd1);
    chk("mrst_underrun", 32'(underrun_cnt), 32'd0);
    chk("mrst_swapped", 32'(swapped), 32'd0);
    chk("mrst_r_data", 32'(r_data), 32'd0);
    tick();
    tick();
    nrst = 1'b1;
    rd(5, d); chk("mrst_rd_invalid", 32'(d), 32'h0000);
    fill(16'h3000, 1920, 1'b1);
    chk("c_w_ready_low", 32'(w_ready), 32'd0);
    do_swap("swap4");
    rd(5, d);    chk("c_rd5", 32'(d), 32'h3005);
    rd(1919, d); chk("c_rd1919", 32'(d), 32'h377F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
